l1mem_ctrl: RTL and testbench
=============================

// Module: l1mem_ctrl
//
// PURPOSE
//   Sequencer for the layer-1/layer-2 buffer memory (128 x 4-bit entries, read as 4 x 128-bit banks).
//   FILL: accepts a valid/ready stream of 4-bit layer-1 results and issues one write per accepted nibble
//   at consecutive addresses 0..N_ENTRY-1.
//   DRAIN: issues the bank reads 0..N_BANK-1 and presents each bank to layer 2 with a valid/ready handshake.
//   Guarantees write and read are never requested in the same cycle.
//
// PARAMETERS
//   N_ENTRY  128  4-bit entries per frame; address width = log2(N_ENTRY) = 7
//   N_BANK   4    128-bit banks per frame; bank address width = log2(N_BANK) = 2
//
// PORTS
//   clock      in   1   single clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   start      in   1   begin a frame; sampled only in IDLE
//   in_valid   in   1   layer-1 nibble valid
//   in_data    in   4   layer-1 nibble
//   in_ready   out  1   controller accepts nibble (high only in FILL)
//   mem_wr     out  1   write strobe to memory (registered)
//   mem_iaddr  out  7   write address (registered)
//   mem_idata  out  4   write data (registered)
//   mem_rd     out  1   read strobe to memory (combinational)
//   mem_oaddr  out  2   bank read address (combinational)
//   out_valid  out  1   memory read data (odata) valid for layer 2
//   out_ready  in   1   layer 2 consumes bank
//   out_bank   out  2   bank index of presented data
//   out_last   out  1   presented bank is N_BANK-1
//   busy       out  1   state != IDLE
//   done       out  1   one-cycle pulse when frame fully drained
//
// BEHAVIOUR
//   Reset: state=IDLE; wcnt=0, rcnt=0; every registered output = 0. Memory contents are not cleared.
//     Reset asserted mid-frame aborts immediately; no further mem_wr/mem_rd.
//   IDLE:
//     in_ready=0, mem_rd=0.
//     start=1 -> FILL, wcnt=0.
//   FILL:
//     in_ready=1.
//     Accept = in_valid & in_ready. On accept: next cycle mem_wr=1, mem_iaddr=wcnt, mem_idata=in_data;
//       wcnt <= wcnt+1.
//     No accept: next cycle mem_wr=0; mem_iaddr/mem_idata hold.
//     Accept while wcnt==N_ENTRY-1 -> DRAIN, rcnt=0, wcnt wraps to 0. This final write appears on
//       mem_wr in the first DRAIN cycle.
//   DRAIN:
//     in_ready=0.
//     Read issue: mem_rd = !mem_wr & (rcnt<N_BANK) & (!out_valid | out_ready). mem_oaddr = rcnt[1:0].
//       On issue, rcnt <= rcnt+1. rcnt is 3 bits so that it can hold N_BANK.
//       The first read therefore issues no earlier than the 2nd DRAIN cycle.
//     Read latency 1: the cycle after mem_rd, out_valid=1, out_bank=issued address, out_last=(address==N_BANK-1).
//       Memory holds odata until the next read.
//     out_valid & out_ready with no read issued that cycle -> out_valid=0 next cycle.
//       Consume and issue in the same cycle -> back-to-back banks, 1 bank/cycle with out_ready tied high.
//     out_valid & out_ready & out_last -> IDLE, done=1 for exactly that next cycle, out_valid=0.
//   mem_wr & mem_rd never high together (checked by assertion).
//   start outside IDLE is ignored. start in the cycle done is high starts a new frame.
//   busy = (state != IDLE), combinational.
//
// TESTING
//   1 Nominal: start, feed 128 nibbles in_data=i%16 with in_valid held high, out_ready=1
//     -> mem_wr on 128 consecutive cycles, mem_iaddr 0..127;
//     -> then mem_rd on 4 cycles, mem_oaddr 0,1,2,3;
//     -> out_valid banks 0..3 with out_last on bank 3; done pulse; busy low after.
//   2 Input gaps: in_valid toggled 1,0,1,0
//     -> mem_iaddr increments only on accepts; mem_wr low in idle cycles; still exactly 128 writes.
//   3 Backpressure: out_ready low 5 cycles on bank 1
//     -> out_valid, out_bank=1 held; no mem_rd until out_ready=1; bank 2 follows next cycle.
//   4 Boundary: last nibble accepted -> DRAIN; the cycle with mem_wr=1 (mem_iaddr=127) has mem_rd=0;
//     first mem_rd (oaddr=0) in the following cycle.
//   5 Reset mid-FILL at wcnt=60 -> next edge all outputs 0, IDLE.
//     New start writes again from mem_iaddr=0.
//   6 start pulsed during FILL and DRAIN -> no effect on counters or state; exactly one done per frame.

Source files
------------

// File: rtl/l1mem_ctrl.sv
// l1mem_ctrl: fill/drain sequencer for the layer-1/layer-2 nibble buffer memory
module l1mem_ctrl #(
  parameter int N_ENTRY = 128,
  parameter int N_BANK  = 4,
  localparam int AW = $clog2(N_ENTRY),
  localparam int BW = $clog2(N_BANK)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [3:0]    in_data,
  output logic          in_ready,
  output logic          mem_wr,
  output logic [AW-1:0] mem_iaddr,
  output logic [3:0]    mem_idata,
  output logic          mem_rd,
  output logic [BW-1:0] mem_oaddr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_bank,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t state;
  logic [AW-1:0] wcnt;
  logic [BW:0] rcnt;
  logic accept, consume;
  assign in_ready  = state == FILL;
  assign busy      = state != IDLE;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  // a read is held off while a write is on the bus and while presented data is still unconsumed
  assign mem_rd    = state == DRAIN && !mem_wr && rcnt < (BW+1)'(N_BANK) && (!out_valid || out_ready);
  assign mem_oaddr = rcnt[BW-1:0];
  // state sequencing, write pipeline register and read-data presentation
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      rcnt      <= '0;
      mem_wr    <= 1'b0;
      mem_iaddr <= '0;
      mem_idata <= '0;
      out_valid <= 1'b0;
      out_bank  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_wr <= accept;
      done   <= 1'b0;
      if (accept) begin
        mem_iaddr <= wcnt;
        mem_idata <= in_data;
        wcnt      <= wcnt == AW'(N_ENTRY-1) ? '0 : wcnt + 1'b1;
      end
      if (mem_rd) begin
        out_valid <= 1'b1;
        out_bank  <= mem_oaddr;
        out_last  <= mem_oaddr == BW'(N_BANK-1);
        rcnt      <= rcnt + 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          state <= FILL;
          wcnt  <= '0;
        end
        FILL: if (accept && wcnt == AW'(N_ENTRY-1)) begin
          state <= DRAIN;
          rcnt  <= '0;
        end
        DRAIN: if (consume && out_last) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // the memory port cannot serve a write and a read in the same cycle
  assert property (@(posedge clock) disable iff (reset) !(mem_wr && mem_rd));
endmodule

// File: tb/tb_l1mem_ctrl.sv
// tb_l1mem_ctrl: scoreboard bench for the buffer memory sequencer
module tb_l1mem_ctrl;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] in_data = '0;
  logic in_ready, mem_wr, mem_rd, out_valid, out_last, busy, done;
  logic [6:0] mem_iaddr;
  logic [3:0] mem_idata;
  logic [1:0] mem_oaddr, out_bank;
  int tests = 0, fails = 0, pend_done = 0;
  logic [10:0] wq[$];
  logic [1:0] rq[$];
  logic [2:0] bq[$];
  bit chk_done = 0, chk_rd0 = 0;

  l1mem_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wr(mem_wr), .mem_iaddr(mem_iaddr), .mem_idata(mem_idata),
    .mem_rd(mem_rd), .mem_oaddr(mem_oaddr), .out_valid(out_valid), .out_ready(out_ready),
    .out_bank(out_bank), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: compare every presented transfer against the queued expectations
  always @(negedge clock) if (!reset) begin
    if (chk_rd0) begin
      check("rd0_after_wr127", {29'd0, mem_rd, mem_oaddr}, 32'b100);
      chk_rd0 = 0;
    end
    if (chk_done) begin
      check("done_after_last", {29'd0, done, out_valid, busy}, 32'b100);
      chk_done = 0;
    end
    if (mem_wr) begin
      if (mem_wr && mem_iaddr == 7'd127) begin
        check("wr127_no_rd", {31'd0, mem_rd}, 32'd0);
        chk_rd0 = 1;
      end
      if (wq.size() == 0) check("wr_extra", {21'd0, mem_iaddr, mem_idata}, 32'hfff);
      else check("wr", {21'd0, mem_iaddr, mem_idata}, {21'd0, wq.pop_front()});
    end
    if (mem_rd) begin
      if (rq.size() == 0) check("rd_extra", {30'd0, mem_oaddr}, 32'hf);
      else check("rd_addr", {30'd0, mem_oaddr}, {30'd0, rq.pop_front()});
    end
    if (out_valid && out_ready) begin
      if (bq.size() == 0) check("bank_extra", {29'd0, out_bank, out_last}, 32'hf);
      else check("bank", {29'd0, out_bank, out_last}, {29'd0, bq.pop_front()});
      if (out_last) chk_done = 1;
    end
    if (done) begin
      check("done_expected", {31'd0, pend_done > 0}, 32'd1);
      if (pend_done > 0) pend_done--;
    end
  end

  task automatic begin_frame();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("fill_entry", {30'd0, busy, in_ready}, 32'b11);
  endtask

  task automatic fill(input int n, input bit gap, input bit pulse);
    int i = 0, cyc = 0;
    while (i < n && cyc < 1000) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      in_data = i[3:0];
      start = pulse && cyc == 41;
      if (in_valid) begin
        wq.push_back({i[6:0], i[3:0]});
        if (i == 127) begin
          for (int b = 0; b < 4; b++) begin
            rq.push_back(b[1:0]);
            bq.push_back({b[1:0], b == 3});
          end
          pend_done++;
        end
        i++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic drain(input bit bp, input bit pulse);
    int n = 0;
    start = pulse;
    @(posedge clock); #1;
    start = 1'b0;
    if (bp) begin
      while (!(out_valid && out_bank == 2'd1) && n < 20) begin
        @(posedge clock); #1;
        n++;
      end
      check("bank1_seen", {31'd0, n < 20}, 32'd1);
      for (int k = 0; k < 5; k++) begin
        out_ready = 1'b0;
        #1;
        check("bp_hold", {28'd0, out_valid, out_bank, mem_rd}, {28'd0, 4'b1010});
        @(posedge clock); #1;
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      check("bank2_next", {29'd0, out_valid, out_bank}, {29'd0, 3'b110});
    end
    n = 0;
    while (!done && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("idle_after", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("queues_empty", wq.size() + rq.size() + bq.size() + pend_done, 32'd0);
  endtask

  initial begin
    #1;
    check("reset_state", {12'd0, mem_wr, mem_iaddr, mem_idata, mem_rd, out_valid, out_bank, out_last, busy, done, in_ready},
          32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    begin_frame();
    fill(128, 1'b0, 1'b0);
    drain(1'b0, 1'b0);
    begin_frame();
    fill(128, 1'b1, 1'b1);
    drain(1'b0, 1'b1);
    begin_frame();
    fill(128, 1'b0, 1'b0);
    drain(1'b1, 1'b0);
    begin_frame();
    fill(60, 1'b0, 1'b0);
    @(negedge clock); #1;
    reset = 1'b1;
    #1;
    check("reset_mid_fill", {12'd0, mem_wr, mem_iaddr, mem_idata, mem_rd, out_valid, out_bank, out_last, busy, done, in_ready},
          32'd0);
    check("reset_flush", wq.size(), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    begin_frame();
    fill(128, 1'b0, 1'b0);
    drain(1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
